// File: rtl/featuremap_channel_reducer.sv
// Reduces CH per-channel conv2D results for one pixel through a pipelined adder tree,
// then adds bias, saturates, optionally applies ReLU, and emits frame-tagged pixels over valid/ready.
module featuremap_channel_reducer #(
  parameter int                           DATA_WIDTH = 16,
  parameter int                           FRAC_BITS  = 8,
  parameter int                           CH         = 8,
  parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0,
  parameter bit                           RELU       = 1'b1,
  parameter int                           WIDTH      = 112,
  parameter int                           HEIGHT     = 112
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [CH*DATA_WIDTH-1:0]     i_data_in,
  input  logic                         i_valid_in,
  output logic                         o_ready_in,
  output logic [DATA_WIDTH-1:0]        o_data_out,
  output logic                         o_valid_out,
  input  logic                         i_ready_out,
  output logic                         o_last_out,
  output logic                         o_frame_done
);

  localparam int S  = $clog2(CH);
  localparam int AW = DATA_WIDTH + S + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic signed [AW:0] SAT_MAX = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW:0] SAT_MIN = {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic int stage_cnt(input int s);
    int n;
    n = CH;
    for (int k = 0; k < s; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Bit offset of stage s inside the flattened operand bus.
  function automatic int stage_off(input int s);
    int off;
    off = 0;
    for (int t = 0; t < s; t++) off += stage_cnt(t) * AW;
    return off;
  endfunction

  localparam int TOT = stage_off(S + 1);

  if (CH < 1 || CH > 64 || FRAC_BITS < 0 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
    $error("featuremap_channel_reducer: illegal CH or FRAC_BITS");
  end

  logic                   w_adv;
  logic                   w_hs;
  logic                   w_last;
  logic [TOT-1:0]         w_bus;
  logic [S:0]             w_vld_bus;
  logic signed [AW-1:0]   w_tree_sum;
  logic signed [AW:0]     w_biased;
  logic [DATA_WIDTH-1:0]  w_sat;
  logic [DATA_WIDTH-1:0]  w_act;

  logic                   r_valid_out;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic [CW-1:0]          r_col;
  logic [RW-1:0]          r_row;
  logic                   r_frame_done;

  assign w_adv  = ~r_valid_out | i_ready_out;
  assign w_hs   = r_valid_out & i_ready_out;
  assign w_last = r_valid_out & (r_col == COL_LAST) & (r_row == ROW_LAST);

  for (genvar s = 0; s <= S; s++) begin : g_st
    localparam int N = stage_cnt(s);
    localparam int O = stage_off(s);
    if (s == 0) begin : g_in
      for (genvar k = 0; k < CH; k++) begin : g_ext
        assign w_bus[k*AW +: AW] = {{(AW-DATA_WIDTH){i_data_in[k*DATA_WIDTH+DATA_WIDTH-1]}},
                                    i_data_in[k*DATA_WIDTH +: DATA_WIDTH]};
      end
      assign w_vld_bus[0] = i_valid_in;
    end else begin : g_add
      localparam int NP = stage_cnt(s - 1);
      localparam int OP = stage_off(s - 1);
      logic [N*AW-1:0] w_nxt;
      logic [N*AW-1:0] r_vec;
      logic            r_vld;
      // Operands were sign-extended to AW, so modular addition here never overflows.
      for (genvar j = 0; j < N; j++) begin : g_pair
        if (2*j + 1 < NP) begin : g_sum
          assign w_nxt[j*AW +: AW] = w_bus[OP + 2*j*AW +: AW] + w_bus[OP + (2*j+1)*AW +: AW];
        end else begin : g_pass
          assign w_nxt[j*AW +: AW] = w_bus[OP + 2*j*AW +: AW];
        end
      end
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vec <= '0;
          r_vld <= 1'b0;
        end else if (w_adv) begin
          r_vec <= w_nxt;
          r_vld <= w_vld_bus[s-1];
        end
      end
      assign w_bus[O +: N*AW] = r_vec;
      assign w_vld_bus[s]     = r_vld;
    end
  end

  assign w_tree_sum = w_bus[stage_off(S) +: AW];
  assign w_biased   = {w_tree_sum[AW-1], w_tree_sum}
                    + {{(AW+1-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS};

  always_comb begin
    w_sat = w_biased[DATA_WIDTH-1:0];
    if (w_biased > SAT_MAX) begin
      w_sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_biased < SAT_MIN) begin
      w_sat = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      w_sat = w_biased[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    w_act = w_sat;
    if (RELU && w_sat[DATA_WIDTH-1]) begin
      w_act = '0;
    end else begin
      w_act = w_sat;
    end
  end

  // Bubbles load zero so data_out reads 0 whenever valid_out is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else if (w_adv) begin
      r_valid_out <= w_vld_bus[S];
      r_data_out  <= w_vld_bus[S] ? w_act : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_hs & w_last;
      if (w_hs) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign o_ready_in   = w_adv;
  assign o_data_out   = r_data_out;
  assign o_valid_out  = r_valid_out;
  assign o_last_out   = w_last;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_featuremap_channel_reducer.sv
// Bench for featuremap_channel_reducer: two instances (biased+ReLU, and unbiased signed)
// with 4x2 frames, checked against a queue of expected pixels.
module tb_featuremap_channel_reducer;
  localparam int DW = 16;
  localparam int CH = 8;
  localparam int NB = CH * DW;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NB-1:0] din_a, din_b;
  logic vin_a, vin_b, rout_a, rout_b;
  logic rdy_a, rdy_b, vout_a, vout_b, last_a, last_b, fd_a, fd_b;
  logic [DW-1:0] dout_a, dout_b;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];

  logic [DW-1:0] sat_lane [7] = '{16'h7FFF, 16'h8000, 16'hFF00, 16'h0100, 16'h0010, 16'h1000, 16'hF000};
  logic [DW-1:0] sat_exp_a[7] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0880, 16'h0100, 16'h7FFF, 16'h0000};
  logic [DW-1:0] sat_exp_b[7] = '{16'h7FFF, 16'h8000, 16'hF800, 16'h0800, 16'h0080, 16'h7FFF, 16'h8000};

  featuremap_channel_reducer #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CH(CH), .BIAS(16'sh0080),
                               .RELU(1'b1), .WIDTH(W), .HEIGHT(H)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(din_a), .i_valid_in(vin_a), .o_ready_in(rdy_a),
    .o_data_out(dout_a), .o_valid_out(vout_a), .i_ready_out(rout_a), .o_last_out(last_a),
    .o_frame_done(fd_a));

  featuremap_channel_reducer #(.DATA_WIDTH(DW), .FRAC_BITS(8), .CH(CH), .BIAS(16'sh0000),
                               .RELU(1'b0), .WIDTH(W), .HEIGHT(H)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(din_b), .i_valid_in(vin_b), .o_ready_in(rdy_b),
    .o_data_out(dout_b), .o_valid_out(vout_b), .i_ready_out(rout_b), .o_last_out(last_b),
    .o_frame_done(fd_b));

  function automatic logic [DW-1:0] model(input logic [NB-1:0] lanes, input int bias, input bit relu);
    int acc;
    logic signed [DW-1:0] v;
    logic [31:0] r;
    acc = bias;
    for (int k = 0; k < CH; k++) begin
      v = lanes[k*DW +: DW];
      acc += int'(v);
    end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    if (relu && acc < 0) acc = 0;
    r = acc;
    return r[DW-1:0];
  endfunction

  task automatic apply_reset(input int n);
    vin_a = 1'b0; vin_b = 1'b0; rout_a = 1'b1; rout_b = 1'b1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
    qa.delete(); qb.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (vout_a !== 1'b0 || vout_b !== 1'b0) begin errors++; $display("FAIL rst_valid got %b%b exp 00", vout_a, vout_b); end
    checks++; if (dout_a !== 16'h0 || dout_b !== 16'h0) begin errors++; $display("FAIL rst_data got %h %h exp 0", dout_a, dout_b); end
    checks++; if (last_a !== 1'b0 || last_b !== 1'b0 || fd_a !== 1'b0 || fd_b !== 1'b0) begin errors++; $display("FAIL rst_last_fd got %b%b%b%b exp 0000", last_a, last_b, fd_a, fd_b); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin errors++; $display("FAIL rst_ready got %b%b exp 11", rdy_a, rdy_b); end
    checks++; if (vout_a !== 1'b0 || vout_b !== 1'b0) begin errors++; $display("FAIL post_rst_valid got %b%b exp 00", vout_a, vout_b); end
  endtask

  task automatic test_latency();
    logic exp_v;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    din_a = {CH{16'h0100}}; vin_a = 1'b1; rout_a = 1'b1;
    #1;
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", rdy_a); end
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      vin_a = 1'b0;
      #1;
      exp_v = (k == 4);
      exp_d = (k == 4) ? 16'h0880 : 16'h0000;
      checks++; if (vout_a !== exp_v) begin errors++; $display("FAIL lat_valid cyc %0d got %b exp %b", k, vout_a, exp_v); end
      checks++; if (dout_a !== exp_d) begin errors++; $display("FAIL lat_data cyc %0d got %h exp %h", k, dout_a, exp_d); end
    end
  endtask

  task automatic test_saturation();
    int sent, ga, gb, cyc;
    sent = 0; ga = 0; gb = 0; cyc = 0;
    while ((ga < 7 || gb < 7) && cyc < 60) begin
      @(negedge clk);
      rout_a = 1'b1; rout_b = 1'b1;
      if (sent < 7) begin
        din_a = {CH{sat_lane[sent]}}; din_b = din_a; vin_a = 1'b1; vin_b = 1'b1;
      end else begin
        vin_a = 1'b0; vin_b = 1'b0;
      end
      #1;
      if (vout_a) begin
        checks++;
        if (qa.size() == 0) begin errors++; $display("FAIL sat_a_extra got %h exp none", dout_a); end
        else begin
          if (dout_a !== qa[0]) begin errors++; $display("FAIL sat_a beat %0d got %h exp %h", ga, dout_a, qa[0]); end
          void'(qa.pop_front());
        end
        ga++;
      end
      if (vout_b) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL sat_b_extra got %h exp none", dout_b); end
        else begin
          if (dout_b !== qb[0]) begin errors++; $display("FAIL sat_b beat %0d got %h exp %h", gb, dout_b, qb[0]); end
          void'(qb.pop_front());
        end
        gb++;
      end
      if (vin_a && rdy_a && vin_b && rdy_b) begin
        qa.push_back(sat_exp_a[sent]); qb.push_back(sat_exp_b[sent]); sent++;
      end
      cyc++;
    end
    vin_a = 1'b0; vin_b = 1'b0;
    checks++; if (ga != 7 || gb != 7) begin errors++; $display("FAIL sat_count got %0d %0d exp 7 7", ga, gb); end
  endtask

  task automatic test_stall();
    int sent, got, cyc;
    logic [DW-1:0] v;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 200) begin
      @(negedge clk);
      rout_b = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 20) begin v = DW'(sent); din_b = {CH{v}}; vin_b = 1'b1; end
      else vin_b = 1'b0;
      #1;
      if (vout_b) begin
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL stall_extra got %h exp none", dout_b); end
        else if (dout_b !== qb[0]) begin errors++; $display("FAIL stall_data out %0d got %h exp %h", got, dout_b, qb[0]); end
        if (rout_b) begin
          if (qb.size() > 0) void'(qb.pop_front());
          got++;
        end else begin
          checks++; if (rdy_b !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", rdy_b); end
        end
      end
      if (vin_b && rdy_b) begin qb.push_back(DW'(8 * sent)); sent++; end
      cyc++;
    end
    vin_b = 1'b0; rout_b = 1'b1;
    checks++; if (got != 20 || qb.size() != 0) begin errors++; $display("FAIL stall_count got %0d left %0d exp 20 0", got, qb.size()); end
    repeat (6) begin
      @(negedge clk); #1;
      checks++; if (vout_b !== 1'b0) begin errors++; $display("FAIL stall_dup got %b exp 0", vout_b); end
    end
  endtask

  task automatic test_frame();
    int sent, got, cyc;
    logic exp_fd, exp_last;
    logic [NB-1:0] lanes;
    apply_reset(2);
    sent = 0; got = 0; cyc = 0; exp_fd = 1'b0; lanes = '0;
    while (got < 24 && cyc < 100) begin
      @(negedge clk);
      if (sent < 24) begin lanes = {$urandom, $urandom, $urandom, $urandom}; din_b = lanes; vin_b = 1'b1; end
      else vin_b = 1'b0;
      #1;
      checks++; if (fd_b !== exp_fd) begin errors++; $display("FAIL frame_done out %0d got %b exp %b", got, fd_b, exp_fd); end
      exp_fd = 1'b0;
      if (vout_b) begin
        exp_last = (got % 8 == 7);
        checks++; if (last_b !== exp_last) begin errors++; $display("FAIL frame_last out %0d got %b exp %b", got, last_b, exp_last); end
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL frame_extra got %h exp none", dout_b); end
        else begin
          if (dout_b !== qb[0]) begin errors++; $display("FAIL frame_data out %0d got %h exp %h", got, dout_b, qb[0]); end
          void'(qb.pop_front());
        end
        exp_fd = exp_last;
        got++;
      end else begin
        checks++; if (last_b !== 1'b0) begin errors++; $display("FAIL frame_last_idle got %b exp 0", last_b); end
      end
      if (vin_b && rdy_b) begin qb.push_back(model(lanes, 0, 1'b0)); sent++; end
      cyc++;
    end
    vin_b = 1'b0;
    @(negedge clk); #1;
    checks++; if (fd_b !== exp_fd) begin errors++; $display("FAIL frame_done_end got %b exp %b", fd_b, exp_fd); end
    checks++; if (got != 24) begin errors++; $display("FAIL frame_count got %0d exp 24", got); end
  endtask

  task automatic test_reset_midframe();
    int sent, got, cyc;
    logic exp_last;
    logic [NB-1:0] lanes;
    apply_reset(2);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      vin_b = (i < 2) || (i >= 8);
      din_b = {CH{16'h0100}};
    end
    @(negedge clk);
    apply_reset(1);
    repeat (8) begin
      @(negedge clk); #1;
      checks++; if (vout_b !== 1'b0 || fd_b !== 1'b0) begin errors++; $display("FAIL midrst_flush got %b%b exp 00", vout_b, fd_b); end
    end
    sent = 0; got = 0; cyc = 0; lanes = '0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      if (sent < 8) begin lanes = {$urandom, $urandom, $urandom, $urandom}; din_b = lanes; vin_b = 1'b1; end
      else vin_b = 1'b0;
      #1;
      if (vout_b) begin
        exp_last = (got == 7);
        checks++; if (last_b !== exp_last) begin errors++; $display("FAIL midrst_last out %0d got %b exp %b", got, last_b, exp_last); end
        checks++;
        if (qb.size() == 0) begin errors++; $display("FAIL midrst_extra got %h exp none", dout_b); end
        else begin
          if (dout_b !== qb[0]) begin errors++; $display("FAIL midrst_data out %0d got %h exp %h", got, dout_b, qb[0]); end
          void'(qb.pop_front());
        end
        got++;
      end
      if (vin_b && rdy_b) begin qb.push_back(model(lanes, 0, 1'b0)); sent++; end
      cyc++;
    end
    vin_b = 1'b0;
    @(negedge clk); #1;
    checks++; if (fd_b !== 1'b1) begin errors++; $display("FAIL midrst_frame_done got %b exp 1", fd_b); end
    checks++; if (got != 8) begin errors++; $display("FAIL midrst_count got %0d exp 8", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    din_a = '0; din_b = '0;
    vin_a = 1'b0; vin_b = 1'b0;
    rout_a = 1'b1; rout_b = 1'b1;
    test_reset();
    test_latency();
    test_saturation();
    test_stall();
    test_frame();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/featuremap_channel_reducer.md
Name: featuremap_channel_reducer

Overview:
Parametrised successor to the per-filter 8-channel bias-add stage. It takes CH per-channel conv2D results for one output pixel and sums them in a pipelined adder tree. It then adds the filter bias, saturates, optionally applies ReLU, and emits one feature-map pixel with a valid/ready handshake and frame position tracking. It sits between the per-channel conv2D instances and the next layer's line buffers/FIFOs. Unlike the fixed 8-channel version, it supports any channel count, backpressure and end-of-frame marking.

Parameters:
DATA_WIDTH, 16, width of each channel sample and output (signed two's complement fixed point)
FRAC_BITS, 8, fractional bits of samples, BIAS and output (format is identical, so no realignment)
CH, 8, number of input channels, 1..64
BIAS, 0, signed DATA_WIDTH bias in the same Q format
RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result
WIDTH, 112, output pixels per row
HEIGHT, 112, output rows per frame

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
data_in  in  CH*DATA_WIDTH  packed channel samples; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
valid_in  in  1  data_in holds a pixel's channel set
ready_in  out  1  block accepts data_in this cycle
data_out  out  DATA_WIDTH  reduced, biased, saturated pixel
valid_out  out  1  data_out valid
ready_out  in  1  downstream accepts data_out
last_out  out  1  qualifies data_out as last pixel of the frame (row HEIGHT-1, col WIDTH-1)
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst=0, async): all pipeline valid bits, data registers, col/row counters, last_out and frame_done are cleared to 0. ready_in is 1 from the first cycle after reset release.
- Accumulator width: AW = DATA_WIDTH + clog2(CH) + 1. Each channel is sign-extended to AW; no intermediate overflow is possible.
- Pipeline structure:
  - S = clog2(CH) adder-tree stages, each halving the operand count. Odd counts pass the leftover operand through a register.
  - Then 1 output stage: add sign-extended BIAS, saturate to [-2^(DW-1), 2^(DW-1)-1], then apply ReLU if RELU=1.
  - Latency L = S+1 cycles from an accepted input to valid_out (CH=1 gives L=1; CH=8 gives L=4).
- Handshake:
  - Global advance enable: adv = ~valid_out | ready_out.
  - ready_in = adv.
  - An input is accepted when valid_in & ready_in.
  - All stages shift only when adv=1. Bubbles propagate as cleared valid bits.
  - Throughput is 1 pixel/cycle with ready_out held high.
  - With ready_out=0 and valid_out=1, data_out, valid_out and last_out are held stable and no input is accepted.
  - Pixel order is preserved; no drop and no duplication.
- Position counters:
  - col/row count output handshakes (valid_out & ready_out).
  - col wraps at WIDTH-1 and increments row; row wraps at HEIGHT-1 back to 0.
  - last_out = valid_out & (col==WIDTH-1) & (row==HEIGHT-1).
  - frame_done is registered: it pulses exactly 1 cycle after the handshake of a last_out beat.
- Simultaneous events: a new input accepted in the same cycle the output is consumed is legal and required for full rate.
- Reset mid-frame: in-flight pixels are discarded and counters return to 0. The next accepted pixel is pixel (0,0).

Test Plan:
- CH=8, FRAC=8, BIAS=0x0080, RELU=1; all lanes 0x0100 (1.0), one beat, ready_out=1 -> valid_out exactly 4 cycles later, data_out=0x0880 (8.5), otherwise 0.
- All lanes 0x7FFF -> data_out=0x7FFF (positive saturation). All lanes 0x8000 with RELU=0 -> 0x8000; same stimulus with RELU=1 -> 0x0000.
- Lanes 0xFF00 (-1.0), BIAS=0, RELU=0 -> 0xF800 (-8.0); RELU=1 -> 0x0000.
- Streaming ramp (lane k = pixel index n) for 20 beats, ready_out toggling 1-0-0-1 -> outputs 8n in order, no loss or duplication; data_out stable while stalled; ready_in=0 whenever valid_out=1 and ready_out=0.
- WIDTH=4, HEIGHT=2, 16 continuous pixels -> last_out on beats 8 and 16; frame_done pulse 1 cycle after each; counters wrap to (0,0).
- Assert rst for 1 cycle with 3 pixels in flight and col=2 -> no valid_out from discarded pixels; next output is treated as (0,0); last_out on the 8th post-reset output (WIDTH=4, HEIGHT=2).
